// File: rtl/hvac_pkg.sv
// Shared types and constants for the HVAC thermostat sequencer.
// Temperatures are unsigned Q8.4 fixed point: 1 LSB = 0.0625 degC.
package hvac_pkg;

    // Sequencer state. The encoding is visible on the top-level 'state' output.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HEAT    = 2'd1,
        ST_COOL    = 2'd2,
        ST_LOCKOUT = 2'd3
    } hvac_state_e;

    // Default timing and format constants
    localparam int DEF_TEMP_W  = 12;
    localparam int DEF_MIN_ON  = 16;
    localparam int DEF_MIN_OFF = 32;
    localparam int FRAC_BITS   = 4;

    // Larger of two integers, used to size the shared dwell counter
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/hvac_dwell_timer.sv
// Saturating dwell counter shared by the on-time and lockout phases.
// The two phases never overlap, so one counter serves both; the FSM
// clears it on every state change.
module hvac_dwell_timer
    import hvac_pkg::*;
#(
    parameter int MIN_ON  = DEF_MIN_ON,
    parameter int MIN_OFF = DEF_MIN_OFF
) (
    input  logic clock,
    input  logic rst,
    input  logic clear,
    output logic on_done,
    output logic off_done
);

    // Counter stops at the largest value either compare ever needs
    localparam int SAT   = max_int(MIN_ON, MIN_OFF) - 1;
    localparam int CNT_W = (SAT < 1) ? 1 : $clog2(SAT + 1);

    localparam logic [CNT_W-1:0] SAT_V    = CNT_W'(SAT);
    localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(MIN_ON - 1);
    localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'(MIN_OFF - 1);

    logic [CNT_W-1:0] cnt;

    // Count cycles spent in the current state, holding at saturation
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (cnt != SAT_V) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Minimum on-time reached (a normal exit is allowed from this cycle on)
    assign on_done  = (cnt >= ON_LAST);
    // Last lockout cycle
    assign off_done = (cnt == OFF_LAST);

endmodule

// File: rtl/hvac_sequencer.sv
// Thermostat sequencer: turns target/ambient/threshold samples into heat (A)
// and cool (B) requests with hysteresis, a minimum on-time and a post-run
// lockout.
//
// Input handshake: sample_valid is a one-cycle strobe with no back-pressure.
// Every cycle it is high counts as a fresh ambient sample; the sequencer
// never stalls the sensor and simply ignores samples it does not need
// (during LOCKOUT, or before the minimum on-time has elapsed).
module hvac_sequencer
    import hvac_pkg::*;
#(
    parameter int TEMP_W  = DEF_TEMP_W,
    parameter int MIN_ON  = DEF_MIN_ON,
    parameter int MIN_OFF = DEF_MIN_OFF
) (
    input  logic              clock,
    input  logic              rst,
    input  logic              enable,
    input  logic              status,
    input  logic [TEMP_W-1:0] target,
    input  logic [TEMP_W-1:0] ambient,
    input  logic [TEMP_W-1:0] threshold,
    input  logic              sample_valid,
    output logic              A,
    output logic              B,
    output logic              lockout,
    output logic [1:0]        state
);

    hvac_state_e state_q;
    hvac_state_e state_d;

    logic on_done;
    logic off_done;
    logic dwell_clear;

    // One extra bit so target + threshold never wraps (4095 + 32 stays 4127)
    logic [TEMP_W:0] tgt_x;
    logic [TEMP_W:0] amb_x;
    logic [TEMP_W:0] thr_x;

    logic heat_call;
    logic cool_call;
    logic heat_sat;
    logic cool_sat;
    logic heat_force;
    logic cool_force;

    assign tgt_x = {1'b0, target};
    assign amb_x = {1'b0, ambient};
    assign thr_x = {1'b0, threshold};

    // Demand: ambient is at least one hysteresis band away from target
    assign heat_call = (tgt_x >= (amb_x + thr_x));
    assign cool_call = ((tgt_x + thr_x) <= amb_x);

    // Satisfied: ambient has reached target
    assign heat_sat = (ambient >= target);
    assign cool_sat = (ambient <= target);

    // Disable or a mode flip ends a run at once, ignoring the minimum on-time
    assign heat_force = !enable || status;
    assign cool_force = !enable || !status;

    // Next-state decision; forced exits are tested before normal exits
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (enable && sample_valid) begin
                    if (!status && heat_call) begin
                        state_d = ST_HEAT;
                    end else if (status && cool_call) begin
                        state_d = ST_COOL;
                    end
                end
            end
            ST_HEAT: begin
                if (heat_force) begin
                    state_d = ST_LOCKOUT;
                end else if (sample_valid && heat_sat && on_done) begin
                    state_d = ST_LOCKOUT;
                end
            end
            ST_COOL: begin
                if (cool_force) begin
                    state_d = ST_LOCKOUT;
                end else if (sample_valid && cool_sat && on_done) begin
                    state_d = ST_LOCKOUT;
                end
            end
            ST_LOCKOUT: begin
                if (off_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Dwell restarts from zero in the first cycle of every new state
    assign dwell_clear = (state_d != state_q);

    hvac_dwell_timer #(
        .MIN_ON  (MIN_ON),
        .MIN_OFF (MIN_OFF)
    ) u_dwell (
        .clock    (clock),
        .rst      (rst),
        .clear    (dwell_clear),
        .on_done  (on_done),
        .off_done (off_done)
    );

    // State register with registered requests; reset drops A/B immediately
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            A       <= 1'b0;
            B       <= 1'b0;
            lockout <= 1'b0;
        end else begin
            state_q <= state_d;
            A       <= (state_d == ST_HEAT);
            B       <= (state_d == ST_COOL);
            lockout <= (state_d == ST_LOCKOUT);
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_hvac_sequencer.sv
// Self-checking bench for hvac_sequencer (TEMP_W=12, MIN_ON=4, MIN_OFF=8).
// Expected {A,B,lockout,state} vectors are queued when stimulus is applied
// and popped after the clock edge that should produce them.
`timescale 1ns/1ps
module tb_hvac_sequencer;
    import hvac_pkg::*;

    localparam int TEMP_W  = 12;
    localparam int MIN_ON  = 4;
    localparam int MIN_OFF = 8;

    // Expected output vectors {A, B, lockout, state}
    localparam logic [4:0] E_IDLE = 5'b000_00;
    localparam logic [4:0] E_HEAT = 5'b100_01;
    localparam logic [4:0] E_COOL = 5'b010_10;
    localparam logic [4:0] E_LOCK = 5'b001_11;

    logic              clock;
    logic              rst;
    logic              enable;
    logic              status;
    logic [TEMP_W-1:0] target;
    logic [TEMP_W-1:0] ambient;
    logic [TEMP_W-1:0] threshold;
    logic              sample_valid;
    logic              A;
    logic              B;
    logic              lockout;
    logic [1:0]        state;

    logic [4:0] exp_q[$];
    logic [4:0] exp_v;
    logic [4:0] obs;
    int checks;
    int errors;

    hvac_sequencer #(
        .TEMP_W  (TEMP_W),
        .MIN_ON  (MIN_ON),
        .MIN_OFF (MIN_OFF)
    ) dut (
        .clock        (clock),
        .rst          (rst),
        .enable       (enable),
        .status       (status),
        .target       (target),
        .ambient      (ambient),
        .threshold    (threshold),
        .sample_valid (sample_valid),
        .A            (A),
        .B            (B),
        .lockout      (lockout),
        .state        (state)
    );

    // Clock and watchdog
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Driver tasks
    task automatic cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic strobe(input logic [TEMP_W-1:0] amb);
        ambient      = amb;
        sample_valid = 1'b1;
        cycle();
        sample_valid = 1'b0;
    endtask

    task automatic drain();
        repeat (MIN_OFF) cycle();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        exp_q.push_back(E_IDLE);
        repeat (2) cycle();
        obs = {A, B, lockout, state}; exp_v = exp_q.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL reset_state: got %b expected %b", obs, exp_v); end
        rst = 1'b1;

        // Enter COOL, then pull reset between clock edges
        status = 1'b1; target = 12'd288; threshold = 12'd32;
        exp_q.push_back(E_COOL);
        strobe(12'd416);
        obs = {A, B, lockout, state}; exp_v = exp_q.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL reset_cool_enter: got %b expected %b", obs, exp_v); end
        cycle();
        #2;
        rst = 1'b0;
        exp_q.push_back(E_IDLE);
        #1;
        obs = {A, B, lockout, state}; exp_v = exp_q.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL reset_async: got %b expected %b", obs, exp_v); end
        rst = 1'b1;

        // No lockout and no request after release without a new sample
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(E_IDLE);
            cycle();
            obs = {A, B, lockout, state}; exp_v = exp_q.pop_front(); checks++;
            if (obs !== exp_v) begin errors++; $display("FAIL reset_release_%0d: got %b expected %b", i, obs, exp_v); end
        end
    endtask

    task automatic test_cool_cycle();
        status = 1'b1; target = 12'd288; threshold = 12'd32;
        exp_q.push_back(E_COOL);
        strobe(12'd416);
        obs = {A, B, lockout, state}; exp_v = exp_q.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL cool_enter: got %b expected %b", obs, exp_v); end
        for (int i = 1; i <= 3; i++) begin
            exp_q.push_back(E_COOL);
            cycle();
            obs = {A, B, lockout, state}; exp_v = exp_q.pop_front(); checks++;
            if (obs !== exp_v) begin errors++; $display("FAIL cool_hold_%0d: got %b expected %b", i, obs, exp_v); end
        end
        exp_q.push_back(E_LOCK);
        strobe(12'd288);
        obs = {A, B, lockout, state}; exp_v = exp_q.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL cool_release: got %b expected %b", obs, exp_v); end
        for (int i = 1; i < MIN_OFF; i++) begin
            exp_q.push_back(E_LOCK);
            cycle();
            obs = {A, B, lockout, state}; exp_v = exp_q.pop_front(); checks++;
            if (obs !== exp_v) begin errors++; $display("FAIL cool_lockout_%0d: got %b expected %b", i, obs, exp_v); end
        end
        exp_q.push_back(E_IDLE);
        cycle();
        obs = {A, B, lockout, state}; exp_v = exp_q.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL cool_back_idle: got %b expected %b", obs, exp_v); end
    endtask

    task automatic test_hysteresis();
        status = 1'b1; target = 12'd288; threshold = 12'd32;
        exp_q.push_back(E_IDLE);
        strobe(12'd319);
        obs = {A, B, lockout, state}; exp_v = exp_q.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL hyst_inside_band: got %b expected %b", obs, exp_v); end
        exp_q.push_back(E_COOL);
        strobe(12'd320);
        obs = {A, B, lockout, state}; exp_v = exp_q.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL hyst_band_edge: got %b expected %b", obs, exp_v); end
        enable = 1'b0;
        exp_q.push_back(E_LOCK);
        cycle();
        obs = {A, B, lockout, state}; exp_v = exp_q.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL hyst_disable: got %b expected %b", obs, exp_v); end
        enable = 1'b1;
        exp_q.push_back(E_IDLE);
        drain();
        obs = {A, B, lockout, state}; exp_v = exp_q.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL hyst_drain: got %b expected %b", obs, exp_v); end
    endtask

    task automatic test_min_on();
        status = 1'b0; target = 12'd416; threshold = 12'd32;
        exp_q.push_back(E_HEAT);
        strobe(12'd288);
        obs = {A, B, lockout, state}; exp_v = exp_q.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL minon_enter: got %b expected %b", obs, exp_v); end
        exp_q.push_back(E_HEAT);
        strobe(12'd416);
        obs = {A, B, lockout, state}; exp_v = exp_q.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL minon_early_dwell0: got %b expected %b", obs, exp_v); end
        exp_q.push_back(E_HEAT);
        cycle();
        obs = {A, B, lockout, state}; exp_v = exp_q.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL minon_hold: got %b expected %b", obs, exp_v); end
        exp_q.push_back(E_HEAT);
        strobe(12'd416);
        obs = {A, B, lockout, state}; exp_v = exp_q.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL minon_early_dwell2: got %b expected %b", obs, exp_v); end
        exp_q.push_back(E_LOCK);
        strobe(12'd416);
        obs = {A, B, lockout, state}; exp_v = exp_q.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL minon_release_dwell3: got %b expected %b", obs, exp_v); end
        exp_q.push_back(E_IDLE);
        drain();
        obs = {A, B, lockout, state}; exp_v = exp_q.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL minon_drain: got %b expected %b", obs, exp_v); end
    endtask

    task automatic test_lockout();
        status = 1'b0; target = 12'd416; threshold = 12'd32;
        exp_q.push_back(E_HEAT);
        strobe(12'd288);
        obs = {A, B, lockout, state}; exp_v = exp_q.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL lock_heat_enter: got %b expected %b", obs, exp_v); end
        repeat (MIN_ON - 1) cycle();
        exp_q.push_back(E_LOCK);
        strobe(12'd416);
        obs = {A, B, lockout, state}; exp_v = exp_q.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL lock_heat_release: got %b expected %b", obs, exp_v); end
        // Qualifying heat sample on every cycle from k+1 onward
        ambient = 12'd288;
        sample_valid = 1'b1;
        for (int i = 1; i < MIN_OFF; i++) begin
            exp_q.push_back(E_LOCK);
            cycle();
            obs = {A, B, lockout, state}; exp_v = exp_q.pop_front(); checks++;
            if (obs !== exp_v) begin errors++; $display("FAIL lock_ignore_%0d: got %b expected %b", i, obs, exp_v); end
        end
        exp_q.push_back(E_IDLE);
        cycle();
        obs = {A, B, lockout, state}; exp_v = exp_q.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL lock_idle_k8: got %b expected %b", obs, exp_v); end
        exp_q.push_back(E_HEAT);
        cycle();
        obs = {A, B, lockout, state}; exp_v = exp_q.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL lock_reassert_k9: got %b expected %b", obs, exp_v); end
        sample_valid = 1'b0;
        enable = 1'b0;
        exp_q.push_back(E_LOCK);
        cycle();
        obs = {A, B, lockout, state}; exp_v = exp_q.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL lock_heat_disable: got %b expected %b", obs, exp_v); end
        enable = 1'b1;
        drain();
    endtask

    task automatic test_forced_exit();
        status = 1'b1; target = 12'd288; threshold = 12'd32;
        exp_q.push_back(E_COOL);
        strobe(12'd416);
        obs = {A, B, lockout, state}; exp_v = exp_q.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL force_cool_enter: got %b expected %b", obs, exp_v); end
        cycle();
        enable = 1'b0;
        exp_q.push_back(E_LOCK);
        cycle();
        obs = {A, B, lockout, state}; exp_v = exp_q.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL force_enable_drop: got %b expected %b", obs, exp_v); end
        enable = 1'b1;
        exp_q.push_back(E_IDLE);
        drain();
        obs = {A, B, lockout, state}; exp_v = exp_q.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL force_drain1: got %b expected %b", obs, exp_v); end

        exp_q.push_back(E_COOL);
        strobe(12'd416);
        obs = {A, B, lockout, state}; exp_v = exp_q.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL force_cool_reenter: got %b expected %b", obs, exp_v); end
        cycle();
        status = 1'b0;
        exp_q.push_back(E_LOCK);
        cycle();
        obs = {A, B, lockout, state}; exp_v = exp_q.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL force_status_flip: got %b expected %b", obs, exp_v); end
        exp_q.push_back(E_IDLE);
        drain();
        obs = {A, B, lockout, state}; exp_v = exp_q.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL force_drain2: got %b expected %b", obs, exp_v); end
    endtask

    task automatic test_overflow();
        target = 12'd4095; threshold = 12'd32;
        status = 1'b0;
        exp_q.push_back(E_IDLE);
        strobe(12'd4095);
        obs = {A, B, lockout, state}; exp_v = exp_q.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL ovf_heat_no_call: got %b expected %b", obs, exp_v); end
        status = 1'b1;
        exp_q.push_back(E_IDLE);
        strobe(12'd4095);
        obs = {A, B, lockout, state}; exp_v = exp_q.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL ovf_cool_no_call: got %b expected %b", obs, exp_v); end
        status = 1'b0;
        exp_q.push_back(E_HEAT);
        strobe(12'd4000);
        obs = {A, B, lockout, state}; exp_v = exp_q.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL ovf_heat_top_range: got %b expected %b", obs, exp_v); end
        enable = 1'b0;
        exp_q.push_back(E_LOCK);
        cycle();
        obs = {A, B, lockout, state}; exp_v = exp_q.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL ovf_disable: got %b expected %b", obs, exp_v); end
        enable = 1'b1;
        drain();
    endtask

    // Test sequence and final report
    initial begin
        checks       = 0;
        errors       = 0;
        rst          = 1'b0;
        enable       = 1'b1;
        status       = 1'b0;
        target       = '0;
        ambient      = '0;
        threshold    = '0;
        sample_valid = 1'b0;

        test_reset();
        test_cool_cycle();
        test_hysteresis();
        test_min_on();
        test_lockout();
        test_forced_exit();
        test_overflow();

        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover: got %0d entries expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
